// File: rtl/int2onehot_pkg.sv
// rtl/int2onehot_pkg.sv - shared constants and helpers for int2onehot_acc (optional thermo output: INT2ONEHOT_ACC_THERMO_EN)
package int2onehot_pkg;

   // Bit mapping of the decoded index.
   localparam logic LSB_FIRST = 1'b0;
   localparam logic MSB_FIRST = 1'b1;

   // Widest vector the popcount helper handles; callers zero-extend into it.
   localparam int POP_MAX_W = 128;

   // Index width for a vector of the given width, never narrower than one bit.
   function automatic int idx_w(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

   // Number of set bits in vec.
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec);
      logic [POP_MAX_W-1:0] v;
      int unsigned          cnt;
      v   = vec;
      cnt = 0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         cnt = cnt + 32'(v[0]);
         v   = v >> 1;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/int2onehot_dec.sv
// rtl/int2onehot_dec.sv - combinational index to one-hot decoder with range error and optional thermometer (INT2ONEHOT_ACC_THERMO_EN)
module int2onehot_dec
   import int2onehot_pkg::*;
#(
   parameter int   WIDTH = 8,
   parameter logic MODE  = LSB_FIRST,
   parameter int   IDX_W = idx_w(WIDTH)
) (
   input  logic [IDX_W-1:0] idx_i,
   output logic [WIDTH-1:0] onehot_o,
`ifdef INT2ONEHOT_ACC_THERMO_EN
   output logic [WIDTH-1:0] thermo_o,
`endif
   output logic             err_o
);

   logic             err;
   logic [WIDTH-1:0] lsb_oh;

   // Decode in LSB-first form; an out-of-range index yields an empty vector.
   always_comb begin
      err    = ({1'b0, idx_i} >= (IDX_W+1)'(WIDTH));
      lsb_oh = err ? '0 : (WIDTH'(1) << idx_i);
   end

   assign err_o = err;

`ifdef INT2ONEHOT_ACC_THERMO_EN
   logic [WIDTH-1:0] lsb_th;

   // Every bit at and below the decoded position: (onehot << 1) - 1.
   always_comb begin
      lsb_th = '0;
      if (!err) begin
         lsb_th = {lsb_oh[WIDTH-2:0], 1'b0} - WIDTH'(1);
      end
   end
`endif

   // MSB-first mode is the bit-reversed LSB-first result.
   for (genvar g = 0; g < WIDTH; g++) begin : g_map
      if (MODE == MSB_FIRST) begin : g_msb
         assign onehot_o[g] = lsb_oh[WIDTH-1-g];
`ifdef INT2ONEHOT_ACC_THERMO_EN
         assign thermo_o[g] = lsb_th[WIDTH-1-g];
`endif
      end else begin : g_lsb
         assign onehot_o[g] = lsb_oh[g];
`ifdef INT2ONEHOT_ACC_THERMO_EN
         assign thermo_o[g] = lsb_th[g];
`endif
      end
   end

endmodule

// File: rtl/int2onehot_acc.sv
// rtl/int2onehot_acc.sv - registered index-to-one-hot decoder with sticky accumulation mask (optional thermo_o: INT2ONEHOT_ACC_THERMO_EN)
module int2onehot_acc
   import int2onehot_pkg::*;
#(
   parameter int   WIDTH = 8,
   parameter logic MODE  = LSB_FIRST,
   parameter int   IDX_W = idx_w(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] onehot_o,
   output logic             err_o,
   output logic             valid_o,
   input  logic             ready_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] acc_o,
   output logic             acc_full_o,
`ifdef INT2ONEHOT_ACC_THERMO_EN
   output logic [WIDTH-1:0] thermo_o,
`endif
   output logic [IDX_W:0]   acc_cnt_o
);

   logic             accept;
   logic [WIDTH-1:0] dec_oh;
   logic             dec_err;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] onehot_q, onehot_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             acc_full_q, acc_full_d;
   logic [IDX_W:0]   acc_cnt_q, acc_cnt_d;

`ifdef INT2ONEHOT_ACC_THERMO_EN
   logic [WIDTH-1:0] dec_th;
   logic [WIDTH-1:0] thermo_q, thermo_d;
`endif

   int2onehot_dec #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .IDX_W (IDX_W)
   ) u_dec (
      .idx_i    (idx_i),
      .onehot_o (dec_oh),
`ifdef INT2ONEHOT_ACC_THERMO_EN
      .thermo_o (dec_th),
`endif
      .err_o    (dec_err)
   );

   // Single pipeline stage: accept whenever the slot is empty or draining this cycle.
   assign ready_o = ~valid_q | ready_i;

   // Next-state for the output register and the accumulation mask.
   always_comb begin
      accept   = valid_i & ready_o;
      valid_d  = valid_q;
      onehot_d = onehot_q;
      err_d    = err_q;
`ifdef INT2ONEHOT_ACC_THERMO_EN
      thermo_d = thermo_q;
`endif
      if (accept) begin
         valid_d  = 1'b1;
         onehot_d = dec_oh;
         err_d    = dec_err;
`ifdef INT2ONEHOT_ACC_THERMO_EN
         thermo_d = dec_th;
`endif
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
      // Clear drops old contents but keeps a bit accepted in the same cycle.
      acc_d      = (clr_i ? '0 : acc_q) | (accept ? dec_oh : '0);
      acc_cnt_d  = (IDX_W+1)'(popcount(POP_MAX_W'(acc_d)));
      acc_full_d = &acc_d;
   end

   // State registers; reset discards any in-flight output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q    <= 1'b0;
         onehot_q   <= '0;
         err_q      <= 1'b0;
         acc_q      <= '0;
         acc_full_q <= 1'b0;
         acc_cnt_q  <= '0;
`ifdef INT2ONEHOT_ACC_THERMO_EN
         thermo_q   <= '0;
`endif
      end else begin
         valid_q    <= valid_d;
         onehot_q   <= onehot_d;
         err_q      <= err_d;
         acc_q      <= acc_d;
         acc_full_q <= acc_full_d;
         acc_cnt_q  <= acc_cnt_d;
`ifdef INT2ONEHOT_ACC_THERMO_EN
         thermo_q   <= thermo_d;
`endif
      end
   end

   assign valid_o    = valid_q;
   assign onehot_o   = onehot_q;
   assign err_o      = err_q;
   assign acc_o      = acc_q;
   assign acc_full_o = acc_full_q;
   assign acc_cnt_o  = acc_cnt_q;
`ifdef INT2ONEHOT_ACC_THERMO_EN
   assign thermo_o   = thermo_q;
`endif

endmodule

// File: tb/tb_int2onehot_acc.sv
// tb/tb_int2onehot_acc.sv - scoreboard bench for int2onehot_acc (W8/LSB, W8/MSB, W6/LSB instances in lockstep)
module tb_int2onehot_acc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [2:0] idx;
   logic       valid_i, ready_i, clr;

   logic       rdy0, rdy1, rdy6, vo0, vo1, vo6;
   logic       err0, err1, err6, full0, full1, full6;
   logic [7:0] oh0, oh1, acc0, acc1;
   logic [5:0] oh6, acc6;
   logic [3:0] cnt0, cnt1, cnt6;
`ifdef INT2ONEHOT_ACC_THERMO_EN
   logic [7:0] th0, th1;
   logic [5:0] th6;
`endif

   int2onehot_acc #(.WIDTH(8), .MODE(1'b0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .idx_i(idx), .valid_i(valid_i), .ready_o(rdy0),
      .onehot_o(oh0), .err_o(err0), .valid_o(vo0), .ready_i(ready_i), .clr_i(clr),
      .acc_o(acc0), .acc_full_o(full0),
`ifdef INT2ONEHOT_ACC_THERMO_EN
      .thermo_o(th0),
`endif
      .acc_cnt_o(cnt0));

   int2onehot_acc #(.WIDTH(8), .MODE(1'b1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .idx_i(idx), .valid_i(valid_i), .ready_o(rdy1),
      .onehot_o(oh1), .err_o(err1), .valid_o(vo1), .ready_i(ready_i), .clr_i(clr),
      .acc_o(acc1), .acc_full_o(full1),
`ifdef INT2ONEHOT_ACC_THERMO_EN
      .thermo_o(th1),
`endif
      .acc_cnt_o(cnt1));

   int2onehot_acc #(.WIDTH(6), .MODE(1'b0)) dut6 (
      .clk_i(clk), .rst_ni(rst_n), .idx_i(idx), .valid_i(valid_i), .ready_o(rdy6),
      .onehot_o(oh6), .err_o(err6), .valid_o(vo6), .ready_i(ready_i), .clr_i(clr),
      .acc_o(acc6), .acc_full_o(full6),
`ifdef INT2ONEHOT_ACC_THERMO_EN
      .thermo_o(th6),
`endif
      .acc_cnt_o(cnt6));

   typedef struct {
      logic [7:0] oh0, oh1, acc0, acc1, th0, th1;
      logic [5:0] oh6, acc6, th6;
      logic       err6;
      int         cnt0, cnt1, cnt6;
   } exp_t;

   exp_t       q[$];
   logic [7:0] m_acc0, m_acc1;
   logic [5:0] m_acc6;
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         t0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one index from posedge+1; push the expectation once the DUT is ready.
   task automatic send(input logic [2:0] i, input logic c);
      exp_t e;
      int   waited;
      waited  = 0;
      idx     = i;
      valid_i = 1'b1;
      clr     = c;
      @(negedge clk);
      while (!rdy0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("send_ready", rdy0, 1'b1);
      if (rdy0) begin
         e.oh0  = 8'h01 << i;
         e.oh1  = 8'h80 >> i;
         e.oh6  = (i < 3'd6) ? (6'h01 << i) : 6'h00;
         e.err6 = (i >= 3'd6);
         e.th0  = '0;
         e.th1  = '0;
         e.th6  = '0;
         for (int k = 0; k <= int'(i); k++) begin
            e.th0[k]   = 1'b1;
            e.th1[7-k] = 1'b1;
            if (i < 3'd6) e.th6[k] = 1'b1;
         end
         m_acc0 = (c ? 8'h00 : m_acc0) | e.oh0;
         m_acc1 = (c ? 8'h00 : m_acc1) | e.oh1;
         m_acc6 = (c ? 6'h00 : m_acc6) | e.oh6;
         e.acc0 = m_acc0;
         e.acc1 = m_acc1;
         e.acc6 = m_acc6;
         e.cnt0 = $countones(m_acc0);
         e.cnt1 = $countones(m_acc1);
         e.cnt6 = $countones(m_acc6);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      clr     = 1'b0;
   endtask

   // Clear-only cycle; ready_i stays high so any pending output drains at the same edge.
   task automatic clear_acc();
      clr     = 1'b1;
      valid_i = 1'b0;
      @(posedge clk);
      #1;
      clr    = 1'b0;
      m_acc0 = '0;
      m_acc1 = '0;
      m_acc6 = '0;
   endtask

   // Monitor: every output transfer pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && vo0 && ready_i) begin
         if (q.size() == 0) begin
            check("sb_underflow", 1'b1, 1'b0);
         end else begin
            e = q.pop_front();
            check("valid1", vo1, 1'b1);
            check("valid6", vo6, 1'b1);
            check("oh0", oh0, e.oh0);
            check("err0", err0, 1'b0);
            check("acc0", acc0, e.acc0);
            check("cnt0", cnt0, e.cnt0);
            check("full0", full0, e.acc0 == 8'hFF);
            check("oh1", oh1, e.oh1);
            check("acc1", acc1, e.acc1);
            check("cnt1", cnt1, e.cnt1);
            check("oh6", oh6, e.oh6);
            check("err6", err6, e.err6);
            check("acc6", acc6, e.acc6);
            check("cnt6", cnt6, e.cnt6);
            check("full6", full6, e.acc6 == 6'h3F);
`ifdef INT2ONEHOT_ACC_THERMO_EN
            check("th0", th0, e.th0);
            check("th1", th1, e.th1);
            check("th6", th6, e.th6);
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b1;
      idx     = '0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      clr     = 1'b0;
      m_acc0  = '0;
      m_acc1  = '0;
      m_acc6  = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", vo0, 1'b0);
      check("rst_oh", oh0, 8'h00);
      check("rst_err", err0, 1'b0);
      check("rst_acc", acc0, 8'h00);
      check("rst_cnt", cnt0, 4'd0);
      check("rst_full", full0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // index 5 appears one cycle after accept
      send(3'd5, 1'b0);
      check("lat_valid", vo0, 1'b1);
      check("lat_oh", oh0, 8'h20);
      check("lat_acc", acc0, 8'h20);
      check("lat_cnt", cnt0, 4'd1);
      clear_acc();

      // MSB-first mapping
      send(3'd0, 1'b0);
      send(3'd7, 1'b0);
      check("mode1_oh", oh1, 8'h01);
      check("mode1_acc", acc1, 8'h81);
      clear_acc();

      // back-to-back 0..7 fills the mask in 8 cycles
      t0 = cyc;
      for (int i = 0; i < 8; i++) send(3'(i), 1'b0);
      check("b2b_cycles", cyc - t0, 8);
      check("b2b_acc", acc0, 8'hFF);
      check("b2b_full", full0, 1'b1);
      check("b2b_cnt", cnt0, 4'd8);
      check("b2b_full6", full6, 1'b1);
      send(3'd3, 1'b1);
      check("clr_acc", acc0, 8'h08);
      check("clr_cnt", cnt0, 4'd1);
      check("clr_full", full0, 1'b0);

      // backpressure: output held, input blocked, nothing lost
      send(3'd2, 1'b0);
      ready_i = 1'b0;
      valid_i = 1'b1;
      idx     = 3'd5;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         check("stall_ready", rdy0, 1'b0);
         check("stall_hold", oh0, 8'h04);
         check("stall_acc", acc0, 8'h0C);
         @(posedge clk);
         #1;
      end
      ready_i = 1'b1;
      send(3'd5, 1'b0);

      // out-of-range indices on the 6-wide instance
      send(3'd6, 1'b0);
      check("w6_err", err6, 1'b1);
      check("w6_oh_err", oh6, 6'h00);
      check("w6_acc_err", acc6, 6'h2C);
      send(3'd7, 1'b0);
      send(3'd2, 1'b0);
      check("w6_oh", oh6, 6'b000100);
      check("w6_ok", err6, 1'b0);

`ifdef INT2ONEHOT_ACC_THERMO_EN
      send(3'd3, 1'b0);
      check("thermo3", th0, 8'h0F);
`endif

      // reset mid-stall clears everything before the next edge
      send(3'd1, 1'b0);
      ready_i = 1'b0;
      valid_i = 1'b1;
      idx     = 3'd3;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", vo0, 1'b0);
      check("arst_oh", oh0, 8'h00);
      check("arst_err", err0, 1'b0);
      check("arst_acc", acc0, 8'h00);
      check("arst_cnt", cnt0, 4'd0);
      check("arst_full", full0, 1'b0);
      check("arst_acc6", acc6, 6'h00);
`ifdef INT2ONEHOT_ACC_THERMO_EN
      check("arst_th", th0, 8'h00);
`endif
      q.delete();
      m_acc0  = '0;
      m_acc1  = '0;
      m_acc6  = '0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(3'd6, 1'b0);
      check("post_rst_acc", acc0, 8'h40);

      repeat (3) @(negedge clk);
      check("sb_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/int2onehot_acc.md
Name: int2onehot_acc

Overview:
Registered index-to-one-hot decoder with a valid/ready handshake and a sticky accumulation mask. It is the inverse of the trailing/leading-zero counter used for priority selection: it turns a binary slot index back into a bit-vector position. It sits on the release/return path of scoreboards and free lists. Typical use: freed tag indices are turned back into mask bits, and the union of returned tags is collected until software or control logic clears it.

Parameters:
- WIDTH, 8: width of the one-hot vector. Must be >= 2; need not be a power of two.
- MODE, 1'b0: bit mapping. 0 means index counts from the LSB (bit idx). 1 means index counts from the MSB (bit WIDTH-1-idx).
- IDX_W, $clog2(WIDTH): index width (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- idx_i  in  IDX_W  index to decode
- valid_i  in  1  idx_i valid
- ready_o  out  1  block can accept idx_i
- onehot_o  out  WIDTH  registered decoded vector
- err_o  out  1  registered flag: accepted index was >= WIDTH (qualified by valid_o)
- valid_o  out  1  onehot_o/err_o valid
- ready_i  in  1  downstream accepts output
- clr_i  in  1  synchronous clear of accumulation mask
- acc_o  out  WIDTH  OR of all accepted one-hot vectors since last clear/reset
- acc_full_o  out  1  acc_o has all WIDTH bits set
- acc_cnt_o  out  IDX_W+1  population count of acc_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni. While reset is asserted, all state is cleared: onehot_o=0, err_o=0, valid_o=0, acc_o=0, acc_full_o=0, acc_cnt_o=0.
- Handshake: input accept = valid_i & ready_o. Output transfer = valid_o & ready_i.
- ready_o = ~valid_o | ready_i. This is a single pipeline register with full throughput and a combinational ready path.
- Latency: exactly 1 cycle. The index accepted in cycle n appears on onehot_o in cycle n+1, with valid_o=1.
- Stall: while valid_o & ~ready_i, onehot_o and err_o are held stable. valid_i may toggle freely during a stall.
- Decode: for idx < WIDTH, onehot_o has exactly one bit set, at position idx (MODE=0) or WIDTH-1-idx (MODE=1).
- Out-of-range index (idx >= WIDTH, possible only when WIDTH is not a power of two):
  - onehot_o = 0, err_o = 1.
  - acc_o is unchanged.
  - The handshake completes normally; no stall.
- Accumulation: acc_o updates at input accept, not at output transfer. So acc_o reflects an accepted index in the same cycle onehot_o presents it.
  - acc_next = (clr_i ? 0 : acc_o) | (accept ? decoded : 0).
  - When clr_i and accept occur in the same cycle, the old contents are dropped and the new bit is kept.
- Duplicate index already set in acc_o: acc_o and acc_cnt_o are unchanged; no error is raised.
- acc_cnt_o and acc_full_o are registered and derived from acc_next, so they are coherent with acc_o every cycle.
- Reset mid-transfer: an in-flight output is discarded. No replay is required.

Optional Feature:
- Macro: INT2ONEHOT_ACC_THERMO_EN.
- When defined:
  - Adds output port thermo_o [WIDTH], registered alongside onehot_o.
  - thermo_o has all bits at and below the decoded position set (MODE=0: bits 0..idx). For MODE=1 the mirrored form applies (bits WIDTH-1-idx..WIDTH-1).
  - thermo_o = 0 on error or reset.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package int2onehot_pkg holds:
  - function idx_w(width) returning max(1, $clog2(width));
  - mode constants LSB_FIRST=1'b0 and MSB_FIRST=1'b1;
  - a popcount function reused by acc_cnt_o.
- One combinational sub-module is natural: int2onehot_dec (index + MODE -> one-hot, err, optional thermometer). It is instantiated once. It is reusable where an unregistered decode is needed.

Test Plan:
(All scenarios use WIDTH=8, MODE=0 unless stated.)
1. Reset release, then idx=5 with valid=1 and ready_i=1 -> next cycle onehot_o=8'b0010_0000, valid_o=1, acc_o=8'h20, acc_cnt_o=1.
2. MODE=1, idx=0 -> onehot_o=8'h80. Then idx=7 -> onehot_o=8'h01, acc_o=8'h81.
3. Back-to-back idx 0..7 with ready_i held high -> 8 transfers in 8 cycles, acc_o=8'hFF, acc_full_o=1, acc_cnt_o=8. Then clr_i together with accept of idx=3 -> acc_o=8'h08, acc_cnt_o=1.
4. Backpressure: ready_i=0 for 3 cycles with valid_i=1 -> ready_o=0 and onehot_o held. Raise ready_i -> no index is lost or duplicated (compare against a scoreboard).
5. WIDTH=6, idx=6 and idx=7 -> onehot_o=0, err_o=1, acc_o unchanged. Then idx=2 -> err_o=0, onehot_o=6'b000100.
6. INT2ONEHOT_ACC_THERMO_EN defined, idx=3 -> thermo_o=8'b0000_1111. Assert rst_ni low mid-stall -> all outputs 0 asynchronously, before the next clock edge.
